// File: rtl/register_file_mp.sv
// Multi-port ID-stage register file: 3 combinational read ports with WB bypass,
// 2 write ports, and a sequential engine that loads each register with its own index.
module register_file_mp #(
    parameter int DATA_W    = 32,
    parameter int REG_COUNT = 16,
    parameter int ADDR_W    = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              init_req_i,
    output logic              ready_o,
    input  logic [ADDR_W-1:0] rd_addr0_i,
    input  logic [ADDR_W-1:0] rd_addr1_i,
    input  logic [ADDR_W-1:0] rd_addr2_i,
    output logic [DATA_W-1:0] rd_data0_o,
    output logic [DATA_W-1:0] rd_data1_o,
    output logic [DATA_W-1:0] rd_data2_o,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] wa0_i,
    input  logic [DATA_W-1:0] wd0_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] wa1_i,
    input  logic [DATA_W-1:0] wd1_i,
    output logic              drop_err_o
);

    typedef enum logic {INIT, RUN} state_e;

    // One extra bit so REG_COUNT == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   REG_COUNT_W = (ADDR_W + 1)'(REG_COUNT);
    localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(REG_COUNT - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                ready_q, ready_d;
    logic                drop_err_q, drop_err_d;
    logic [DATA_W-1:0]   regs_q [REG_COUNT];

    logic                wa0_ok, wa1_ok;
    logic                wr0_en, wr1_en;
    logic [ADDR_W-1:0]   rd_addr [3];

    assign wa0_ok = ({1'b0, wa0_i} < REG_COUNT_W);
    assign wa1_ok = ({1'b0, wa1_i} < REG_COUNT_W);
    assign wr0_en = we0_i && ready_q && wa0_ok;
    assign wr1_en = we1_i && ready_q && wa1_ok;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ready_d    = ready_q;
        drop_err_d = drop_err_q | (we0_i && !wr0_en) | (we1_i && !wr1_en);
        case (state_q)
            INIT: begin
                idx_d = idx_q + ADDR_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                    idx_d   = '0;
                end
            end
            RUN: begin
                if (init_req_i) begin
                    state_d = INIT;
                    idx_d   = '0;
                    ready_d = 1'b0;
                end
            end
            default: begin
                state_d = INIT;
                idx_d   = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= INIT;
            idx_q      <= '0;
            ready_q    <= 1'b0;
            drop_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ready_q    <= ready_d;
            drop_err_q <= drop_err_d;
        end
    end

    // Storage has no reset; the init engine provides the known contents.
    // Port 1 is applied last so it wins a same-address collision.
    always_ff @(posedge clk_i) begin
        if (state_q == INIT) begin
            regs_q[idx_q] <= DATA_W'(idx_q);
        end
        if (wr0_en) begin
            regs_q[wa0_i] <= wd0_i;
        end
        if (wr1_en) begin
            regs_q[wa1_i] <= wd1_i;
        end
    end

    assign rd_addr = '{rd_addr0_i, rd_addr1_i, rd_addr2_i};

    for (genvar p = 0; p < 3; p++) begin : g_rd
        logic [DATA_W-1:0] data;
        always_comb begin
            data = '0;
            if (ready_q && ({1'b0, rd_addr[p]} < REG_COUNT_W)) begin
                if (we1_i && (wa1_i == rd_addr[p])) begin
                    data = wd1_i;
                end else if (we0_i && (wa0_i == rd_addr[p])) begin
                    data = wd0_i;
                end else begin
                    data = regs_q[rd_addr[p]];
                end
            end
        end
    end

    assign rd_data0_o = g_rd[0].data;
    assign rd_data1_o = g_rd[1].data;
    assign rd_data2_o = g_rd[2].data;
    assign ready_o    = ready_q;
    assign drop_err_o = drop_err_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: a 16-entry and a 12-entry instance share stimulus;
// expectations are queued as stimulus is driven and popped when outputs are sampled.
module tb_register_file_mp;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic        initReq;
    logic [3:0]  rdAddr0, rdAddr1, rdAddr2;
    logic        we0, we1;
    logic [3:0]  wa0, wa1;
    logic [31:0] wd0, wd1;

    logic [31:0] rdDataA0, rdDataA1, rdDataA2;
    logic        readyA, dropErrA;
    logic [31:0] rdDataB0, rdDataB1, rdDataB2;
    logic        readyB, dropErrB;

    exp_t sbQ[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    register_file_mp #(.DATA_W(32), .REG_COUNT(16), .ADDR_W(4)) dutA (
        .clk_i(clk), .rst_ni(rstN), .init_req_i(initReq), .ready_o(readyA),
        .rd_addr0_i(rdAddr0), .rd_addr1_i(rdAddr1), .rd_addr2_i(rdAddr2),
        .rd_data0_o(rdDataA0), .rd_data1_o(rdDataA1), .rd_data2_o(rdDataA2),
        .we0_i(we0), .wa0_i(wa0), .wd0_i(wd0),
        .we1_i(we1), .wa1_i(wa1), .wd1_i(wd1),
        .drop_err_o(dropErrA)
    );

    register_file_mp #(.DATA_W(32), .REG_COUNT(12), .ADDR_W(4)) dutB (
        .clk_i(clk), .rst_ni(rstN), .init_req_i(initReq), .ready_o(readyB),
        .rd_addr0_i(rdAddr0), .rd_addr1_i(rdAddr1), .rd_addr2_i(rdAddr2),
        .rd_data0_o(rdDataB0), .rd_data1_o(rdDataB1), .rd_data2_o(rdDataB2),
        .we0_i(we0), .wa0_i(wa0), .wd0_i(wd0),
        .we1_i(we1), .wa1_i(wa1), .wd1_i(wd1),
        .drop_err_o(dropErrB)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic w0, input logic [3:0] a0, input logic [31:0] d0,
                                 input logic w1, input logic [3:0] a1, input logic [31:0] d1,
                                 input logic req);
        we0 = w0; wa0 = a0; wd0 = d0;
        we1 = w1; wa1 = a1; wd1 = d1;
        initReq = req;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0);
    endtask

    task automatic setReads(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
        rdAddr0 = a0; rdAddr1 = a1; rdAddr2 = a2;
        #1;
    endtask

    task automatic pushExp(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sbQ.push_back(e);
    endtask

    task automatic checkOutput(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sbQ.size() == 0) begin
            bad++;
            $error("[TB] FAIL sb_empty observed=%h expected=<none>", obs);
        end else begin
            e = sbQ.pop_front();
            assert (obs === e.exp) else begin
                bad++;
                $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    initial begin
        rstN = 1'b0;
        initReq = 1'b0;
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        rdAddr0 = '0; rdAddr1 = '0; rdAddr2 = '0;
        #12;
        pushExp("rst_readyA", 32'd0);
        pushExp("rst_dropA", 32'd0);
        pushExp("rst_rdA0", 32'd0);
        checkOutput(32'(readyA));
        checkOutput(32'(dropErrA));
        checkOutput(rdDataA0);

        // First init after reset release
        @(posedge clk);
        #1;
        rstN = 1'b1;
        setReads(4'd3, 4'd3, 4'd3);
        for (int c = 1; c <= 16; c++) begin
            tick();
            pushExp($sformatf("init1_readyA_c%0d", c), 32'(c >= 16));
            pushExp($sformatf("init1_readyB_c%0d", c), 32'(c >= 12));
            checkOutput(32'(readyA));
            checkOutput(32'(readyB));
            if (c == 8) begin
                pushExp("init1_rdA0_forced", 32'd0);
                checkOutput(rdDataA0);
            end
        end

        setReads(4'd3, 4'd7, 4'd15);
        pushExp("rdA0_r3", 32'h3);
        pushExp("rdA1_r7", 32'h7);
        pushExp("rdA2_r15", 32'hF);
        pushExp("rdB0_r3", 32'h3);
        pushExp("rdB1_r7", 32'h7);
        pushExp("rdB2_r15_oor", 32'h0);
        checkOutput(rdDataA0); checkOutput(rdDataA1); checkOutput(rdDataA2);
        checkOutput(rdDataB0); checkOutput(rdDataB1); checkOutput(rdDataB2);

        // Port 0 bypass, then the committed value
        setReads(4'd5, 4'd0, 4'd0);
        applyStimulus(1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0, 32'd0, 1'b0);
        pushExp("byp0_A", 32'hDEADBEEF);
        pushExp("byp0_B", 32'hDEADBEEF);
        checkOutput(rdDataA0); checkOutput(rdDataB0);
        tick();
        idle();
        pushExp("wr0_A", 32'hDEADBEEF);
        pushExp("wr0_B", 32'hDEADBEEF);
        checkOutput(rdDataA0); checkOutput(rdDataB0);

        // Both ports to the same address: port 1 wins
        setReads(4'd0, 4'd2, 4'd0);
        applyStimulus(1'b1, 4'd2, 32'h11, 1'b1, 4'd2, 32'h22, 1'b0);
        pushExp("bypcoll_A", 32'h22);
        pushExp("bypcoll_B", 32'h22);
        checkOutput(rdDataA1); checkOutput(rdDataB1);
        tick();
        idle();
        pushExp("wrcoll_A", 32'h22);
        pushExp("wrcoll_B", 32'h22);
        checkOutput(rdDataA1); checkOutput(rdDataB1);

        // Address 13: in range for A, out of range for B
        setReads(4'd0, 4'd0, 4'd13);
        applyStimulus(1'b1, 4'd13, 32'h55, 1'b0, 4'd0, 32'd0, 1'b0);
        pushExp("oor_byp_A", 32'h55);
        pushExp("oor_byp_B", 32'h0);
        pushExp("oor_drop_pre_B", 32'd0);
        checkOutput(rdDataA2); checkOutput(rdDataB2); checkOutput(32'(dropErrB));
        tick();
        idle();
        pushExp("oor_rd_A", 32'h55);
        pushExp("oor_rd_B", 32'h0);
        pushExp("oor_drop_A", 32'd0);
        pushExp("oor_drop_B", 32'd1);
        checkOutput(rdDataA2); checkOutput(rdDataB2);
        checkOutput(32'(dropErrA)); checkOutput(32'(dropErrB));

        setReads(4'd0, 4'd0, 4'd12);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd12, 32'h66, 1'b0);
        tick();
        idle();
        pushExp("oor12_rd_A", 32'h66);
        pushExp("oor12_rd_B", 32'h0);
        pushExp("drop_sticky_B", 32'd1);
        pushExp("drop_clean_A", 32'd0);
        checkOutput(rdDataA2); checkOutput(rdDataB2);
        checkOutput(32'(dropErrB)); checkOutput(32'(dropErrA));

        // init_req with a same-cycle write, then a re-init with a dropped write and an ignored init_req
        setReads(4'd4, 4'd5, 4'd2);
        applyStimulus(1'b1, 4'd4, 32'hAA, 1'b0, 4'd0, 32'd0, 1'b1);
        pushExp("req_byp_A", 32'hAA);
        pushExp("req_ready_pre_A", 32'd1);
        checkOutput(rdDataA0); checkOutput(32'(readyA));
        tick();
        idle();
        pushExp("req_readyA_0", 32'd0);
        pushExp("req_readyB_0", 32'd0);
        pushExp("req_rdA0_forced", 32'd0);
        checkOutput(32'(readyA)); checkOutput(32'(readyB)); checkOutput(rdDataA0);
        for (int c = 1; c <= 16; c++) begin
            if (c == 4) applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd1, 32'h99, 1'b0);
            if (c == 6) applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1);
            tick();
            idle();
            pushExp($sformatf("init2_readyA_c%0d", c), 32'(c >= 16));
            pushExp($sformatf("init2_readyB_c%0d", c), 32'(c >= 12));
            checkOutput(32'(readyA));
            checkOutput(32'(readyB));
            if (c == 4) begin
                pushExp("init_drop_A", 32'd1);
                checkOutput(32'(dropErrA));
            end
        end
        pushExp("reinit_A_r4", 32'h4);
        pushExp("reinit_A_r5", 32'h5);
        pushExp("reinit_A_r2", 32'h2);
        pushExp("reinit_B_r4", 32'h4);
        pushExp("reinit_B_r5", 32'h5);
        pushExp("reinit_B_r2", 32'h2);
        checkOutput(rdDataA0); checkOutput(rdDataA1); checkOutput(rdDataA2);
        checkOutput(rdDataB0); checkOutput(rdDataB1); checkOutput(rdDataB2);
        setReads(4'd1, 4'd13, 4'd12);
        pushExp("reinit_A_r1", 32'h1);
        pushExp("reinit_A_r13", 32'hD);
        pushExp("reinit_A_r12", 32'hC);
        pushExp("reinit_B_r1", 32'h1);
        pushExp("reinit_B_r13", 32'h0);
        pushExp("reinit_B_r12", 32'h0);
        checkOutput(rdDataA0); checkOutput(rdDataA1); checkOutput(rdDataA2);
        checkOutput(rdDataB0); checkOutput(rdDataB1); checkOutput(rdDataB2);

        // Reset asserted mid-init at idx 9
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1);
        tick();
        idle();
        for (int c = 1; c <= 9; c++) tick();
        rstN = 1'b0;
        #1;
        pushExp("midrst_readyA", 32'd0);
        pushExp("midrst_dropA", 32'd0);
        pushExp("midrst_dropB", 32'd0);
        checkOutput(32'(readyA)); checkOutput(32'(dropErrA)); checkOutput(32'(dropErrB));
        tick();
        rstN = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c == 11 || c == 12) begin
                pushExp($sformatf("init3_readyB_c%0d", c), 32'(c >= 12));
                checkOutput(32'(readyB));
            end
            if (c == 15 || c == 16) begin
                pushExp($sformatf("init3_readyA_c%0d", c), 32'(c >= 16));
                checkOutput(32'(readyA));
            end
        end
        for (int a = 0; a < 16; a++) begin
            int a1;
            int a2;
            a1 = (a + 5) % 16;
            a2 = (a + 11) % 16;
            setReads(4'(a), 4'(a1), 4'(a2));
            pushExp($sformatf("sweepA_p0_r%0d", a), 32'(a));
            pushExp($sformatf("sweepA_p1_r%0d", a1), 32'(a1));
            pushExp($sformatf("sweepA_p2_r%0d", a2), 32'(a2));
            pushExp($sformatf("sweepB_p0_r%0d", a), (a < 12) ? 32'(a) : 32'd0);
            checkOutput(rdDataA0); checkOutput(rdDataA1); checkOutput(rdDataA2);
            checkOutput(rdDataB0);
        end

        if (sbQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL sb_leftover observed=%0d expected=0", sbQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
